skid_pipe: RTL and testbench
============================

# skid_pipe

Two-entry valid/ready register slice that registers both the forward path (`pout_valid`, `pout_data`) and the backward path (`pin_ready`). It breaks the combinational `pout_ready` → `pin_ready` path that the single-register pipeline stage leaves open. It is inserted between core pipeline stages, or at bus boundaries, wherever the ready chain limits timing. Full throughput is sustained with one-cycle latency.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pin_valid`  in  1  upstream payload valid.
- `pin_data`  in  DATA_WIDTH  upstream payload.
- `pin_ready`  out  1  upstream may transfer. Driven directly from a flop, with no combinational input dependence.
- `pout_valid`  out  1  downstream payload valid. Driven directly from a flop.
- `pout_data`  out  DATA_WIDTH  downstream payload. Forced to all-zero whenever `pout_valid`=0.
- `pout_ready`  in  1  downstream accepts.
- `count`  out  2  occupancy (0, 1 or 2), for debug and assertions.

## Operation
- Storage:
  - Output register `out_q`, which always holds the head entry.
  - Skid register `skid_q`, which holds the second entry.
- Transfer definitions:
  - Input transfer: `ins` = `pin_valid` & `pin_ready`.
  - Output transfer: `outs` = `pout_valid` & `pout_ready`.
- State machine, 2-bit encoding:
  - EMPTY (count 0): `ins` → load `out_q` from `pin_data`, go to BUSY.
  - BUSY (count 1):
    - `ins` & `outs` → load `out_q`, stay BUSY.
    - `ins` & !`outs` → load `skid_q`, go to FULL.
    - !`ins` & `outs` → go to EMPTY.
    - Otherwise hold.
  - FULL (count 2): `outs` → `out_q` ← `skid_q`, go to BUSY. `ins` is impossible because `pin_ready`=0.
  - Illegal encoding → EMPTY on the next edge, with data undefined.
- Registered outputs:
  - `pin_ready` flop ← (next_state ≠ FULL).
  - `pout_valid` flop ← (next_state ≠ EMPTY).
- Data ordering is strict FIFO; no entry is ever dropped or duplicated.
- Payload registers are not reset. Only the state, `pin_ready` and `pout_valid` flops are reset.

## Timing
- Reset values while `rst`=1: state EMPTY, `pout_valid`=0, `pout_data`=0, `pin_ready`=0, `count`=0.
- `pin_ready` rises on the first `clk` edge after `rst` deasserts. No transfer is accepted on that edge.
- Latency: data accepted at edge N appears on `pout_data` with `pout_valid`=1 after edge N.
- Throughput: with `pout_ready` held at 1, one transfer per cycle, and the slice stays in BUSY.
- Backpressure: when `pout_ready` drops with the slice in BUSY, one more beat is absorbed into `skid_q`. `pin_ready` falls after that same edge.
- Upstream protocol rules:
  - Upstream must hold `pin_valid` and `pin_data` stable while `pin_ready`=0.
  - The slice holds `pout_valid`/`pout_data` stable while `pout_ready`=0.
- Simultaneous `ins` and `outs` in BUSY: the new data replaces the head and the occupancy is unchanged.
- Reset mid-operation: all buffered entries are discarded and the outputs immediately take their reset values. No glitch on `pin_ready` to 1 while `rst`=1.

## Structure
- A shared core package holds:
  - The state encoding constants: `SKID_EMPTY`=2'd0, `SKID_BUSY`=2'd1, `SKID_FULL`=2'd2.
  - The reset-enable polarity constant used core-wide.
- No sub-module is needed. The block consists of one next-state combinational process plus the flop processes.

## Test plan
- Reset then stream: assert `rst` for 3 cycles, then drive `pin_valid`=1 with data 1..8 and hold `pout_ready`=1. Required: `pin_ready` rises one edge after release, and data 1..8 appear on consecutive cycles with 1-cycle latency and `count`=1 throughout.
- Backpressure absorption: stream 0xA0, 0xA1, 0xA2 and drop `pout_ready` in the cycle 0xA0 is presented. Required: 0xA1 is absorbed, `count`=2, and `pin_ready`=0 after that edge. 0xA2 is held upstream, and on `pout_ready`=1 the output order is 0xA0, 0xA1, 0xA2.
- Drain: fill to FULL with 0x11, 0x22, then set `pin_valid`=0 and `pout_ready`=1. Required: 0x11 then 0x22 are output, then `pout_valid`=0 with `pout_data`=0 and `count`=0.
- Random valid/ready: 10k cycles of random `pin_valid` and `pout_ready` at 50% each. Required: a scoreboard shows in-order, lossless delivery, with `pout_data` stable under stall and `count` ≤ 2.
- Reset while FULL: assert `rst` asynchronously mid-cycle. Required: `pout_valid`=0, `pout_data`=0, `pin_ready`=0 and `count`=0 immediately, with no stale data emitted after release.

Source files
------------

// File: rtl/skid_pipe_pkg.sv
// Shared core definitions for the skid_pipe register slice: state encoding
// and the reset polarity used across the core.
package skid_pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam logic RST_ACTIVE = 1'b1;

endpackage

// File: rtl/skid_pipe.sv
// Two-entry valid/ready register slice: registers pout_valid/pout_data and
// pin_ready so no combinational path crosses the slice.
module skid_pipe
  import skid_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pin_valid,
  input  logic [DATA_WIDTH-1:0] pin_data,
  output logic                  pin_ready,
  output logic                  pout_valid,
  output logic [DATA_WIDTH-1:0] pout_data,
  input  logic                  pout_ready,
  output logic [1:0]            count
);

  skid_state_e           state_q;
  skid_state_e           next_state;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  ins;
  logic                  outs;
  logic                  load_out;
  logic                  load_skid;
  logic                  pop_skid;

  assign ins  = pin_valid & pin_ready;
  assign outs = pout_valid & pout_ready;

  always_comb begin
    next_state = state_q;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    pop_skid   = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (ins) begin
          load_out   = 1'b1;
          next_state = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (ins && outs) begin
          load_out = 1'b1;
        end else if (ins) begin
          load_skid  = 1'b1;
          next_state = SKID_FULL;
        end else if (outs) begin
          next_state = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (outs) begin
          pop_skid   = 1'b1;
          next_state = SKID_BUSY;
        end
      end
      default: next_state = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q    <= SKID_EMPTY;
      pin_ready  <= 1'b0;
      pout_valid <= 1'b0;
    end else begin
      state_q    <= next_state;
      pin_ready  <= (next_state != SKID_FULL);
      pout_valid <= (next_state != SKID_EMPTY);
    end
  end

  // Payload registers carry no reset; pout_data masking hides stale contents.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_q <= pin_data;
    end else if (pop_skid) begin
      out_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= pin_data;
    end
  end

  assign pout_data = pout_valid ? out_q : '0;
  assign count     = state_q;

endmodule

// File: tb/tb_skid_pipe.sv
// Directed and scoreboarded random checks for the skid_pipe register slice.
module tb_skid_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        pin_valid;
  logic [31:0] pin_data;
  logic        pin_ready;
  logic        pout_valid;
  logic [31:0] pout_data;
  logic        pout_ready;
  logic [1:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  skid_pipe #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_valid  (pin_valid),
    .pin_data   (pin_data),
    .pin_ready  (pin_ready),
    .pout_valid (pout_valid),
    .pout_data  (pout_data),
    .pout_ready (pout_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] c, input logic r);
    check({tag, ".valid"}, 32'(pout_valid), 32'(v));
    check({tag, ".data"},  pout_data, d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".ready"}, 32'(pin_ready), 32'(r));
  endtask

  logic [31:0] sb[$];
  logic [31:0] exp_head;
  logic [31:0] held_data;
  logic        held_valid;
  logic        s_ins;
  logic        s_outs;

  initial begin
    rst        = 1'b1;
    pin_valid  = 1'b0;
    pin_data   = '0;
    pout_ready = 1'b0;

    // Reset then stream 1..8
    repeat (3) tick();
    check_out("rst", 1'b0, 32'h0, 2'd0, 1'b0);
    rst        = 1'b0;
    pin_valid  = 1'b1;
    pin_data   = 32'd1;
    pout_ready = 1'b1;
    @(negedge clk);
    check("rel.ready_low", 32'(pin_ready), 32'd0);
    tick();
    check_out("rel.edge1", 1'b0, 32'h0, 2'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1, 1'b1);
      if (i < 8) pin_data = 32'(i + 1);
      else       pin_valid = 1'b0;
    end
    tick();
    check_out("stream.end", 1'b0, 32'h0, 2'd0, 1'b1);

    // Backpressure absorption
    pin_valid = 1'b1;
    pin_data  = 32'hA0;
    tick();
    check_out("bp.a0", 1'b1, 32'hA0, 2'd1, 1'b1);
    pout_ready = 1'b0;
    pin_data   = 32'hA1;
    tick();
    check_out("bp.a1abs", 1'b1, 32'hA0, 2'd2, 1'b0);
    pin_data = 32'hA2;
    tick();
    check_out("bp.stall", 1'b1, 32'hA0, 2'd2, 1'b0);
    pout_ready = 1'b1;
    tick();
    check_out("bp.out_a1", 1'b1, 32'hA1, 2'd1, 1'b1);
    tick();
    check_out("bp.out_a2", 1'b1, 32'hA2, 2'd1, 1'b1);
    pin_valid = 1'b0;
    tick();
    check_out("bp.empty", 1'b0, 32'h0, 2'd0, 1'b1);

    // Drain from FULL
    pout_ready = 1'b0;
    pin_valid  = 1'b1;
    pin_data   = 32'h11;
    tick();
    pin_data = 32'h22;
    tick();
    check_out("drain.full", 1'b1, 32'h11, 2'd2, 1'b0);
    pin_valid  = 1'b0;
    pout_ready = 1'b1;
    tick();
    check_out("drain.22", 1'b1, 32'h22, 2'd1, 1'b1);
    tick();
    check_out("drain.empty", 1'b0, 32'h0, 2'd0, 1'b1);

    // Random valid/ready with scoreboard
    held_valid = 1'b0;
    held_data  = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      pout_ready = 1'($urandom_range(0, 1));
      if (!(pin_valid && !pin_ready)) begin
        pin_valid = 1'($urandom_range(0, 1));
        pin_data  = $urandom;
      end
      s_ins  = pin_valid & pin_ready;
      s_outs = pout_valid & pout_ready;
      held_valid = pout_valid & ~pout_ready;
      held_data  = pout_data;
      if (s_outs) begin
        if (sb.size() == 0) begin
          check("rnd.spurious", 32'(pout_valid), 32'd0);
        end else begin
          exp_head = sb.pop_front();
          check("rnd.order", pout_data, exp_head);
        end
      end
      if (s_ins) sb.push_back(pin_data);
      tick();
      check("rnd.count", 32'(count), 32'(sb.size()));
      if (held_valid) begin
        check("rnd.stall_valid", 32'(pout_valid), 32'd1);
        check("rnd.stall_data", pout_data, held_data);
      end
    end
    pin_valid  = 1'b0;
    pout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (pout_valid && sb.size() != 0) begin
        exp_head = sb.pop_front();
        check("rnd.drain", pout_data, exp_head);
      end
      tick();
    end
    check("rnd.left", 32'(sb.size()), 32'd0);
    check_out("rnd.final", 1'b0, 32'h0, 2'd0, 1'b1);

    // Asynchronous reset while FULL
    pout_ready = 1'b0;
    pin_valid  = 1'b1;
    pin_data   = 32'h55;
    tick();
    pin_data = 32'h66;
    tick();
    check_out("rf.full", 1'b1, 32'h55, 2'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("rf.async", 1'b0, 32'h0, 2'd0, 1'b0);
    pin_valid  = 1'b0;
    pout_ready = 1'b1;
    tick();
    check_out("rf.held", 1'b0, 32'h0, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("rf.rel1", 1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    check_out("rf.rel2", 1'b0, 32'h0, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
